// File: rtl/xbox_xlr_pkg.sv
// Shared types and constants for the XBOX line-copy sequencer.
package xbox_xlr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_WR   = 2'd3
    } xlr_state_t;

    localparam int REG_CTRL = 0;
    localparam int REG_SRC  = 1;
    localparam int REG_DST  = 2;
    localparam int REG_LEN  = 3;
    localparam int REG_CNT  = 4;
    localparam int REG_PAT  = 5;

    localparam int STAT_DONE    = 0;
    localparam int STAT_BUSY    = 1;
    localparam int STAT_ERR     = 2;
    localparam int STAT_ABORTED = 3;

    localparam int FIELD_LINE_LSB = 0;
    localparam int FIELD_MEM_LSB  = 16;
    localparam int FIELD_W        = 16;

    // True when the instance index is out of range or the block runs past the last line.
    function automatic logic range_bad(input logic [15:0] mem_idx,
                                       input logic [15:0] line,
                                       input logic [15:0] count,
                                       input int          num_mems,
                                       input int          log2_lines);
        logic [16:0] end_line;
        end_line = {1'b0, line} + {1'b0, count};
        return (mem_idx >= 16'(num_mems)) || (end_line > (17'd1 << log2_lines));
    endfunction

endpackage

// File: rtl/xbox_xlr_port_mux.sv
// Steers one read and one write request onto the per-instance memory ports.
module xbox_xlr_port_mux
    import xbox_xlr_pkg::*;
#(
    parameter int NUM_MEMS = 2,
    parameter int ADDR_W   = 4,
    parameter int IDX_W    = 1
) (
    input  logic                                rd_en,
    input  logic [IDX_W-1:0]                    rd_mem,
    input  logic [ADDR_W-1:0]                   rd_addr,
    input  logic                                wr_en,
    input  logic [IDX_W-1:0]                    wr_mem,
    input  logic [ADDR_W-1:0]                   wr_addr,
    input  logic [7:0][31:0]                    wr_data,
    output logic [NUM_MEMS-1:0][ADDR_W-1:0]     xlr_mem_addr,
    output logic [NUM_MEMS-1:0][7:0][31:0]      xlr_mem_wdata,
    output logic [NUM_MEMS-1:0][31:0]           xlr_mem_be,
    output logic [NUM_MEMS-1:0]                 xlr_mem_rd,
    output logic [NUM_MEMS-1:0]                 xlr_mem_wr
);

    // Per-instance steering; instances without a request are held at zero.
    always_comb begin
        xlr_mem_addr  = {(NUM_MEMS*ADDR_W){1'b0}};
        xlr_mem_wdata = {(NUM_MEMS*256){1'b0}};
        xlr_mem_be    = {(NUM_MEMS*32){1'b0}};
        xlr_mem_rd    = {NUM_MEMS{1'b0}};
        xlr_mem_wr    = {NUM_MEMS{1'b0}};
        for (int i = 0; i < NUM_MEMS; i++) begin
            if (wr_en && (wr_mem == IDX_W'(i))) begin
                xlr_mem_addr[i]  = wr_addr;
                xlr_mem_wdata[i] = wr_data;
                xlr_mem_be[i]    = {32{1'b1}};
                xlr_mem_wr[i]    = 1'b1;
            end else if (rd_en && (rd_mem == IDX_W'(i))) begin
                xlr_mem_addr[i]  = rd_addr;
                xlr_mem_rd[i]    = 1'b1;
            end else begin
                xlr_mem_addr[i]  = {ADDR_W{1'b0}};
                xlr_mem_rd[i]    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/xbox_xlr_copy_ctrl.sv
// Host-programmed line-copy sequencer (RD -> CAP -> WR per line).
// Optional fill mode is compiled in with XBOX_COPY_FILL_EN.
module xbox_xlr_copy_ctrl
    import xbox_xlr_pkg::*;
#(
    parameter int NUM_MEMS           = 2,
    parameter int LOG2_LINES_PER_MEM = 4
) (
    input  logic                                            clk,
    input  logic                                            rst,
    output logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]     xlr_mem_addr,
    output logic [NUM_MEMS-1:0][7:0][31:0]                  xlr_mem_wdata,
    output logic [NUM_MEMS-1:0][31:0]                       xlr_mem_be,
    output logic [NUM_MEMS-1:0]                             xlr_mem_rd,
    output logic [NUM_MEMS-1:0]                             xlr_mem_wr,
    input  logic [NUM_MEMS-1:0][7:0][31:0]                  xlr_mem_rdata,
    input  logic [31:0][31:0]                               host_regs,
    input  logic [31:0]                                     host_regs_valid_pulse,
    output logic [31:0][31:0]                               host_regs_data_out,
    output logic [31:0]                                     host_regs_valid_out
);

    localparam int IDX_W = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1;
    localparam int CNT_W = LOG2_LINES_PER_MEM + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    xlr_state_t       state_r, state_s;
    logic [IDX_W-1:0] src_mem_r, dst_mem_r;
    logic [CNT_W-1:0] cur_src_r, cur_dst_r, len_r, done_cnt_r;
    logic [7:0][31:0] buf_r;
    logic             done_r, busy_r, err_r, aborted_r, fill_r;

    logic             go_s, abort_req_s, fill_go_s, src_bad_s, dst_bad_s, cmd_bad_s;
    logic             start_s, cmd_err_s, cmd_empty_s, abort_s, wr_s, last_s;
    logic [15:0]      len_f_s;
    logic [31:0]      status_s;
    logic             unused_s;

    assign go_s        = host_regs_valid_pulse[REG_CTRL] & host_regs[REG_CTRL][0];
    assign abort_req_s = host_regs_valid_pulse[REG_CTRL] & host_regs[REG_CTRL][1];
    assign len_f_s     = host_regs[REG_LEN][15:0];

`ifdef XBOX_COPY_FILL_EN
    assign fill_go_s = host_regs[REG_LEN][31];
`else
    assign fill_go_s = 1'b0;
`endif

    assign src_bad_s = range_bad(host_regs[REG_SRC][FIELD_MEM_LSB +: FIELD_W],
                                 host_regs[REG_SRC][FIELD_LINE_LSB +: FIELD_W],
                                 len_f_s, NUM_MEMS, LOG2_LINES_PER_MEM);
    assign dst_bad_s = range_bad(host_regs[REG_DST][FIELD_MEM_LSB +: FIELD_W],
                                 host_regs[REG_DST][FIELD_LINE_LSB +: FIELD_W],
                                 len_f_s, NUM_MEMS, LOG2_LINES_PER_MEM);
    // Fill commands never read, so the source range is irrelevant to them.
    assign cmd_bad_s = dst_bad_s | (src_bad_s & ~fill_go_s);

    assign unused_s = ^{host_regs, host_regs_valid_pulse, cur_src_r, cur_dst_r};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s     = state_r;
        start_s     = 1'b0;
        cmd_err_s   = 1'b0;
        cmd_empty_s = 1'b0;
        abort_s     = 1'b0;
        wr_s        = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (go_s) begin
                    if (cmd_bad_s) begin
                        cmd_err_s = 1'b1;
                    end else if (len_f_s == 16'd0) begin
                        cmd_empty_s = 1'b1;
                    end else begin
                        start_s = 1'b1;
                        state_s = fill_go_s ? ST_WR : ST_RD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (abort_req_s) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CAP;
                end
            end
            ST_CAP: begin
                if (abort_req_s) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WR;
                end
            end
            ST_WR: begin
                wr_s   = 1'b1;
                last_s = ((done_cnt_r + CNT_ONE) == len_r);
                if (abort_req_s) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else if (last_s) begin
                    state_s = ST_IDLE;
                end else if (fill_r) begin
                    state_s = ST_WR;
                end else begin
                    state_s = ST_RD;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Command latch, line buffer, address/line counters and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_mem_r  <= {IDX_W{1'b0}};
            dst_mem_r  <= {IDX_W{1'b0}};
            cur_src_r  <= {CNT_W{1'b0}};
            cur_dst_r  <= {CNT_W{1'b0}};
            len_r      <= {CNT_W{1'b0}};
            done_cnt_r <= {CNT_W{1'b0}};
            buf_r      <= {256{1'b0}};
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
            aborted_r  <= 1'b0;
            fill_r     <= 1'b0;
        end else if (start_s) begin
            src_mem_r  <= host_regs[REG_SRC][FIELD_MEM_LSB +: IDX_W];
            dst_mem_r  <= host_regs[REG_DST][FIELD_MEM_LSB +: IDX_W];
            cur_src_r  <= host_regs[REG_SRC][FIELD_LINE_LSB +: CNT_W];
            cur_dst_r  <= host_regs[REG_DST][FIELD_LINE_LSB +: CNT_W];
            len_r      <= len_f_s[CNT_W-1:0];
            done_cnt_r <= {CNT_W{1'b0}};
            done_r     <= 1'b0;
            busy_r     <= 1'b1;
            err_r      <= 1'b0;
            aborted_r  <= 1'b0;
            fill_r     <= fill_go_s;
            if (fill_go_s) begin
                buf_r <= {8{host_regs[REG_PAT]}};
            end else begin
                buf_r <= buf_r;
            end
        end else if (cmd_err_s || cmd_empty_s) begin
            done_cnt_r <= {CNT_W{1'b0}};
            done_r     <= 1'b1;
            err_r      <= cmd_err_s;
            aborted_r  <= 1'b0;
        end else begin
            if (state_r == ST_CAP) begin
                buf_r <= xlr_mem_rdata[src_mem_r];
            end
            if (wr_s) begin
                cur_src_r  <= cur_src_r + CNT_ONE;
                cur_dst_r  <= cur_dst_r + CNT_ONE;
                done_cnt_r <= done_cnt_r + CNT_ONE;
            end
            if (abort_s) begin
                busy_r    <= 1'b0;
                done_r    <= 1'b1;
                aborted_r <= 1'b1;
            end else if (wr_s && last_s) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end
        end
    end

    // Status words shown to the host in place of reg0 and reg4.
    always_comb begin
        status_s               = 32'd0;
        status_s[STAT_DONE]    = done_r;
        status_s[STAT_BUSY]    = busy_r;
        status_s[STAT_ERR]     = err_r;
        status_s[STAT_ABORTED] = aborted_r;
        host_regs_data_out           = {1024{1'b0}};
        host_regs_data_out[REG_CTRL] = status_s;
        host_regs_data_out[REG_CNT]  = {{(32-CNT_W){1'b0}}, done_cnt_r};
    end

    assign host_regs_valid_out = (32'd1 << REG_CTRL) | (32'd1 << REG_CNT);

    xbox_xlr_port_mux #(
        .NUM_MEMS (NUM_MEMS),
        .ADDR_W   (LOG2_LINES_PER_MEM),
        .IDX_W    (IDX_W)
    ) u_port_mux (
        .rd_en         (state_r == ST_RD),
        .rd_mem        (src_mem_r),
        .rd_addr       (cur_src_r[LOG2_LINES_PER_MEM-1:0]),
        .wr_en         (state_r == ST_WR),
        .wr_mem        (dst_mem_r),
        .wr_addr       (cur_dst_r[LOG2_LINES_PER_MEM-1:0]),
        .wr_data       (buf_r),
        .xlr_mem_addr  (xlr_mem_addr),
        .xlr_mem_wdata (xlr_mem_wdata),
        .xlr_mem_be    (xlr_mem_be),
        .xlr_mem_rd    (xlr_mem_rd),
        .xlr_mem_wr    (xlr_mem_wr)
    );

endmodule

// File: tb/tb_xbox_xlr_copy_ctrl.sv
// Self-checking bench: memory model plus ordered-copy reference for xbox_xlr_copy_ctrl.
module tb_xbox_xlr_copy_ctrl;

    localparam int NM = 2;
    localparam int LW = 4;
    localparam int NL = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NM-1:0][LW-1:0]    xlr_mem_addr;
    logic [NM-1:0][7:0][31:0] xlr_mem_wdata;
    logic [NM-1:0][31:0]      xlr_mem_be;
    logic [NM-1:0]            xlr_mem_rd, xlr_mem_wr;
    logic [NM-1:0][7:0][31:0] xlr_mem_rdata;
    logic [31:0][31:0]        host_regs = '0;
    logic [31:0]              host_regs_valid_pulse = '0;
    logic [31:0][31:0]        host_regs_data_out;
    logic [31:0]              host_regs_valid_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_rd = 0, n_wr = 0, idle_viol = 0;
    int wr_cyc[$], wr_mem[$], wr_addr[$];
    logic [255:0] wr_data[$];

    logic [255:0] mem     [NM][NL];
    logic [255:0] exp_mem [NM][NL];
    logic         ld_en = 1'b0;
    int           ld_m = 0, ld_l = 0;
    logic [255:0] ld_d = '0;

    xbox_xlr_copy_ctrl #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(LW)) dut (
        .clk(clk), .rst(rst),
        .xlr_mem_addr(xlr_mem_addr), .xlr_mem_wdata(xlr_mem_wdata), .xlr_mem_be(xlr_mem_be),
        .xlr_mem_rd(xlr_mem_rd), .xlr_mem_wr(xlr_mem_wr), .xlr_mem_rdata(xlr_mem_rdata),
        .host_regs(host_regs), .host_regs_valid_pulse(host_regs_valid_pulse),
        .host_regs_data_out(host_regs_data_out), .host_regs_valid_out(host_regs_valid_out)
    );

    always #5 clk = ~clk;

    function automatic int port_violations();
        int v = 0;
        for (int i = 0; i < NM; i++) begin
            if (xlr_mem_rd[i] && xlr_mem_wr[i]) v++;
            if (xlr_mem_wr[i] && xlr_mem_be[i] !== 32'hFFFF_FFFF) v++;
            if (!xlr_mem_rd[i] && !xlr_mem_wr[i] &&
                ((|xlr_mem_addr[i]) || (|xlr_mem_wdata[i]) || (|xlr_mem_be[i]))) v++;
        end
        return v;
    endfunction

    // Memory model: rdata one cycle after rd, writes logged with their cycle number.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        n_rd      <= n_rd + $countones(xlr_mem_rd);
        n_wr      <= n_wr + $countones(xlr_mem_wr);
        idle_viol <= idle_viol + port_violations();
        for (int i = 0; i < NM; i++) begin
            if (ld_en && ld_m == i) mem[i][ld_l] <= ld_d;
            if (xlr_mem_wr[i]) begin
                mem[i][xlr_mem_addr[i]] <= xlr_mem_wdata[i];
                wr_cyc.push_back(cyc);
                wr_mem.push_back(i);
                wr_addr.push_back(int'(xlr_mem_addr[i]));
                wr_data.push_back(xlr_mem_wdata[i]);
            end
            if (xlr_mem_rd[i]) xlr_mem_rdata[i] <= mem[i][xlr_mem_addr[i]];
            else               xlr_mem_rdata[i] <= {8{32'(cyc) ^ 32'hDEAD_BEEF}};
        end
    end

    // Called at a negedge; pulses reg0 for one cycle and returns the go cycle T.
    task automatic issue_go(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                            input logic [31:0] c, output int t);
        host_regs[1] = s;
        host_regs[2] = d;
        host_regs[3] = l;
        host_regs[0] = c;
        host_regs_valid_pulse[0] = 1'b1;
        @(negedge clk);
        host_regs_valid_pulse[0] = 1'b0;
        t = cyc - 1;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 200; i++) begin
            if (host_regs_data_out[0][0] === 1'b1) begin
                dc = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int m = 0; m < NM; m++)
            for (int l = 0; l < NL; l++) begin
                ld_d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                exp_mem[m][l] = ld_d;
                ld_m = m; ld_l = l; ld_en = 1'b1;
                @(negedge clk);
            end
        ld_en = 1'b0;
        checks++;
        if ((|{xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr}) !== 1'b0) begin
            errors++; $display("FAIL reset_ports got nonzero outputs while rst high, want 0");
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (host_regs_data_out[0] !== 32'd0 || host_regs_data_out[4] !== 32'd0) begin
            errors++; $display("FAIL reset_status got reg0=%0h reg4=%0h want 0 0",
                               host_regs_data_out[0], host_regs_data_out[4]);
        end
        checks++;
        if (host_regs_valid_out !== 32'h0000_0011) begin
            errors++; $display("FAIL reset_valid_out got %0h want 11", host_regs_valid_out);
        end
    endtask

    task automatic test_copy();
        for (int it = 0; it < 8; it++) begin
            int sm, sl, dm, dl, n, t, dc, base, idx;
            logic [255:0] ed[$];
            ed.delete();
            if (it == 0) begin
                sm = 0; sl = 2; dm = 1; dl = 8; n = 4;
            end else begin
                n  = $urandom_range(1, 8);
                sm = $urandom_range(0, NM - 1);
                dm = $urandom_range(0, NM - 1);
                sl = $urandom_range(0, NL - n);
                dl = $urandom_range(0, NL - n);
            end
            for (int k = 0; k < n; k++) begin
                ed.push_back(exp_mem[sm][sl + k]);
                exp_mem[dm][dl + k] = exp_mem[sm][sl + k];
            end
            base = wr_cyc.size();
            issue_go({16'(sm), 16'(sl)}, {16'(dm), 16'(dl)}, 32'(n), 32'h1, t);
            wait_done(dc);
            checks++;
            if (dc !== t + 3 * n + 1) begin
                errors++; $display("FAIL copy%0d_done_cycle got %0d want %0d", it, dc - t, 3 * n + 1);
            end
            checks++;
            if (host_regs_data_out[0] !== 32'h1 || host_regs_data_out[4] !== 32'(n)) begin
                errors++; $display("FAIL copy%0d_status got reg0=%0h reg4=%0d want 1 %0d",
                                   it, host_regs_data_out[0], host_regs_data_out[4], n);
            end
            checks++;
            if (wr_cyc.size() - base !== n) begin
                errors++; $display("FAIL copy%0d_write_count got %0d want %0d", it, wr_cyc.size() - base, n);
            end
            for (int k = 0; k < n; k++) begin
                idx = base + k;
                checks++;
                if (idx >= wr_cyc.size() || wr_cyc[idx] != t + 3 * (k + 1) || wr_mem[idx] != dm ||
                    wr_addr[idx] != dl + k || wr_data[idx] !== ed[k]) begin
                    errors++;
                    if (idx < wr_cyc.size())
                        $display("FAIL copy%0d_write%0d got cyc+%0d mem%0d addr%0d data%0h want cyc+%0d mem%0d addr%0d data%0h",
                                 it, k, wr_cyc[idx] - t, wr_mem[idx], wr_addr[idx], wr_data[idx],
                                 3 * (k + 1), dm, dl + k, ed[k]);
                    else
                        $display("FAIL copy%0d_write%0d got none want mem%0d addr%0d", it, k, dm, dl + k);
                end
            end
        end
    endtask

    task automatic test_range_error();
        int t, dc, r0, w0;
        r0 = n_rd; w0 = n_wr;
        issue_go({16'd2, 16'd0}, {16'd1, 16'd0}, 32'd1, 32'h1, t);
        wait_done(dc);
        checks++;
        if (dc !== t + 1 || host_regs_data_out[0] !== 32'h5) begin
            errors++; $display("FAIL err_src_mem got done+%0d reg0=%0h want +1 5", dc - t, host_regs_data_out[0]);
        end
        issue_go({16'd0, 16'd0}, {16'd1, 16'd14}, 32'd3, 32'h1, t);
        wait_done(dc);
        checks++;
        if (dc !== t + 1 || host_regs_data_out[0] !== 32'h5) begin
            errors++; $display("FAIL err_dst_line got done+%0d reg0=%0h want +1 5", dc - t, host_regs_data_out[0]);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (n_rd !== r0 || n_wr !== w0) begin
            errors++; $display("FAIL err_no_strobes got rd=%0d wr=%0d want 0 0", n_rd - r0, n_wr - w0);
        end
        for (int k = 0; k < 3; k++) exp_mem[1][13 + k] = exp_mem[0][13 + k];
        issue_go({16'd0, 16'd13}, {16'd1, 16'd13}, 32'd3, 32'h1, t);
        wait_done(dc);
        checks++;
        if (dc !== t + 10 || host_regs_data_out[0] !== 32'h1) begin
            errors++; $display("FAIL edge_last_line got done+%0d reg0=%0h want +10 1", dc - t, host_regs_data_out[0]);
        end
    endtask

    task automatic test_zero_len();
        int t, dc, r0, w0;
        r0 = n_rd; w0 = n_wr;
        issue_go({16'd0, 16'd3}, {16'd1, 16'd3}, 32'd0, 32'h3, t);
        wait_done(dc);
        repeat (3) @(negedge clk);
        checks++;
        if (dc !== t + 1 || host_regs_data_out[0] !== 32'h1 || host_regs_data_out[4] !== 32'd0) begin
            errors++; $display("FAIL zero_len got done+%0d reg0=%0h reg4=%0d want +1 1 0",
                               dc - t, host_regs_data_out[0], host_regs_data_out[4]);
        end
        checks++;
        if (n_rd !== r0 || n_wr !== w0) begin
            errors++; $display("FAIL zero_len_strobes got rd=%0d wr=%0d want 0 0", n_rd - r0, n_wr - w0);
        end
    endtask

    task automatic test_go_while_busy();
        int t, t2, dc, base;
        base = wr_cyc.size();
        for (int k = 0; k < 3; k++) exp_mem[1][4 + k] = exp_mem[0][k];
        issue_go({16'd0, 16'd0}, {16'd1, 16'd4}, 32'd3, 32'h1, t);
        repeat (3) @(negedge clk);
        issue_go({16'd1, 16'd0}, {16'd0, 16'd0}, 32'd1, 32'h1, t2);
        wait_done(dc);
        checks++;
        if (dc !== t + 10 || host_regs_data_out[4] !== 32'd3) begin
            errors++; $display("FAIL busy_go_done got done+%0d reg4=%0d want +10 3", dc - t, host_regs_data_out[4]);
        end
        checks++;
        if (wr_cyc.size() - base !== 3 || wr_mem[base + 2] != 1 || wr_addr[base + 2] != 6 ||
            wr_data[base + 2] !== exp_mem[1][6]) begin
            errors++; $display("FAIL busy_go_writes got count=%0d want 3 ending at mem1 line6", wr_cyc.size() - base);
        end
    endtask

    task automatic test_abort();
        int t, r0, w0, base;
        r0 = n_rd; w0 = n_wr; base = wr_cyc.size();
        exp_mem[1][0] = exp_mem[0][4];
        issue_go({16'd0, 16'd4}, {16'd1, 16'd0}, 32'd4, 32'h1, t);
        repeat (4) @(negedge clk);
        host_regs[0] = 32'h3;
        host_regs_valid_pulse[0] = 1'b1;
        @(negedge clk);
        host_regs_valid_pulse[0] = 1'b0;
        checks++;
        if (host_regs_data_out[0] !== 32'h9 || host_regs_data_out[4] !== 32'd1) begin
            errors++; $display("FAIL abort_status got reg0=%0h reg4=%0d want 9 1",
                               host_regs_data_out[0], host_regs_data_out[4]);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (n_wr - w0 !== 1 || n_rd - r0 !== 2) begin
            errors++; $display("FAIL abort_strobes got wr=%0d rd=%0d want 1 2", n_wr - w0, n_rd - r0);
        end
        checks++;
        if (wr_cyc.size() <= base || wr_cyc[base] != t + 3 || wr_data[base] !== exp_mem[1][0]) begin
            errors++; $display("FAIL abort_first_write got none or wrong timing/data want cyc+3");
        end
    endtask

    task automatic test_reset_mid();
        int t, dc, w0;
        w0 = n_wr;
        exp_mem[0][10] = exp_mem[0][8];
        exp_mem[0][11] = exp_mem[0][9];
        issue_go({16'd0, 16'd8}, {16'd0, 16'd10}, 32'd4, 32'h1, t);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ((|{xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr}) !== 1'b0 ||
            host_regs_data_out[0] !== 32'd0 || host_regs_data_out[4] !== 32'd0) begin
            errors++; $display("FAIL reset_mid_outputs got reg0=%0h reg4=%0d or active ports want all 0",
                               host_regs_data_out[0], host_regs_data_out[4]);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (n_wr - w0 !== 2) begin
            errors++; $display("FAIL reset_mid_writes got %0d want 2", n_wr - w0);
        end
        exp_mem[0][0] = exp_mem[1][0];
        exp_mem[0][1] = exp_mem[1][1];
        issue_go({16'd1, 16'd0}, {16'd0, 16'd0}, 32'd2, 32'h1, t);
        wait_done(dc);
        checks++;
        if (dc !== t + 7 || host_regs_data_out[0] !== 32'h1) begin
            errors++; $display("FAIL reset_mid_recopy got done+%0d reg0=%0h want +7 1", dc - t, host_regs_data_out[0]);
        end
    endtask

`ifdef XBOX_COPY_FILL_EN
    task automatic test_fill();
        int t, dc, base;
        base = wr_cyc.size();
        host_regs[5] = 32'hA5A5_A5A5;
        for (int k = 0; k < 3; k++) exp_mem[0][k] = {8{32'hA5A5_A5A5}};
        issue_go({16'd3, 16'd0}, {16'd0, 16'd0}, 32'h8000_0003, 32'h1, t);
        wait_done(dc);
        checks++;
        if (dc !== t + 4) begin
            errors++; $display("FAIL fill_done got done+%0d want +4", dc - t);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (wr_cyc.size() <= base + k || wr_cyc[base + k] != t + 1 + k ||
                wr_addr[base + k] != k || wr_data[base + k] !== {8{32'hA5A5_A5A5}}) begin
                errors++; $display("FAIL fill_write%0d got missing or wrong want cyc+%0d addr%0d pattern", k, 1 + k, k);
            end
        end
    endtask
`endif

    task automatic test_final_state();
        for (int m = 0; m < NM; m++)
            for (int l = 0; l < NL; l++) begin
                checks++;
                if (mem[m][l] !== exp_mem[m][l]) begin
                    errors++; $display("FAIL mem%0d_line%0d got %0h want %0h", m, l, mem[m][l], exp_mem[m][l]);
                end
            end
        checks++;
        if (idle_viol !== 0) begin
            errors++; $display("FAIL port_rules got %0d violations want 0", idle_viol);
        end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_range_error();
        test_zero_len();
        test_go_while_busy();
        test_abort();
        test_reset_mid();
`ifdef XBOX_COPY_FILL_EN
        test_fill();
`endif
        test_final_state();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xbox_xlr_copy_ctrl.md
# xbox_xlr_copy_ctrl

Host-programmed line-copy sequencer for the XBOX accelerator memory ports. It sits in the accelerator slot of the XBOX and is configured through the APB-mapped host register file. Each command moves a block of 32-byte lines from one memory instance/line to another over the `xlr_mem_*` interface, then reports completion and errors in a status register.

## Interface
- `NUM_MEMS`, default 2: number of XBOX memory instances driven.
- `LOG2_LINES_PER_MEM`, default 4: line-address width per instance.
- `clk`  in  1: sole clock.
- `rst`  in  1: synchronous, active-high reset.
- `xlr_mem_addr`  out  [NUM_MEMS][LOG2_LINES_PER_MEM]: line address per instance.
- `xlr_mem_wdata`  out  [NUM_MEMS][8][32]: write line per instance.
- `xlr_mem_be`  out  [NUM_MEMS][32]: byte enables per instance.
- `xlr_mem_rd` / `xlr_mem_wr`  out  [NUM_MEMS]: read/write strobes.
- `xlr_mem_rdata`  in  [NUM_MEMS][8][32]: read line. Valid exactly 1 cycle after `rd`.
- `host_regs`  in  [32][32]: host-written register contents.
- `host_regs_valid_pulse`  in  32: one-cycle pulse per register write.
- `host_regs_data_out`  out  [32][32]: accelerator-sourced read data.
- `host_regs_valid_out`  out  32: per-register override enable.

## Operation
**Command registers**
- reg1 holds the source: [31:16] mem index, [15:0] line.
- reg2 holds the destination, in the same format.
- reg3[15:0] holds the line count N.
- reg0 is the control register. A write with bit0=1 is `go`. A write with bit1=1 is `abort`.

**Status**
- reg0 is accelerator-owned: `host_regs_valid_out[0]`=1 always. Data bits: bit0 done, bit1 busy, bit2 err, bit3 aborted; other bits 0.
- reg4 is also accelerator-owned: the count of lines written for the current/last command. All other `valid_out` bits are 0.

**State machine: IDLE, RD, CAP, WR**
- **IDLE**
  - On `go`, latch src, dst and N, and clear done/err/aborted.
  - Error case: if a mem index ≥ NUM_MEMS, or line+N > 2^LOG2_LINES_PER_MEM on either side, set err=1 and done=1, and stay in IDLE with no memory access.
  - If N=0, set done=1 with no access.
  - Otherwise set busy=1 and go to RD.
- **RD:** drive `rd` and `addr`=cur_src on the source instance, then go to CAP.
- **CAP:** register the source `rdata` into a 256-bit line buffer, then go to WR.
- **WR:** drive `wr`, `addr`=cur_dst, `be`=all ones and `wdata`=the buffer on the destination instance. Increment src, dst and lines-done.
  - If lines-done reaches N: clear busy, set done, go to IDLE.
  - Otherwise go to RD.
- **Same instance:** src and dst may share an instance, including overlapping ranges. The copy proceeds in ascending line order.
- **Idle ports:** any instance not addressed in a cycle gets addr/wdata/be/rd/wr = 0.
- **go while busy:** ignored, with no state change.
- **abort while busy:** takes effect at the end of the current cycle. Any WR in that cycle still completes. The block then returns to IDLE with busy=0, done=1, aborted=1. reg4 shows the lines actually written.
- **go and abort in the same write:** abort wins if busy; go wins if idle.

## Timing
- **Reset:** all `xlr_mem_*` outputs are 0, the state is IDLE, and status is 0. reg0 reads 0 with `valid_out[0]`=1; reg4 reads 0.
- **Reset mid-command:** the command is dropped immediately, with no further strobes.
- **Per-line cost:** 3 cycles. With `go` sampled in cycle T, the first `rd` is in cycle T+1 and the first `wr` in T+3. The k-th `wr` (1-based) is in cycle T+3k.
- **Completion:** done=1 and busy=0 are visible from cycle T+3N+1.
- **Error and N=0:** done is visible from cycle T+1.
- **Width rule:** internal line counters are LOG2_LINES_PER_MEM+1 bits wide, so the range check cannot wrap.

## Configuration
- `XBOX_COPY_FILL_EN` defined: reg3[31]=1 selects fill mode.
  - RD and CAP are skipped; each line costs 1 cycle.
  - The line buffer is loaded with reg5 replicated 8× at `go`.
  - Only the dst range is checked.
  - Completion timing is T+N+1.
- `XBOX_COPY_FILL_EN` undefined: reg3[31] is ignored and every command is a copy.

## Structure
- Package `xbox_xlr_pkg`:
  - the state enum;
  - the register index localparams (CTRL=0, SRC=1, DST=2, LEN=3, CNT=4, PAT=5);
  - the status bit positions;
  - the src/dst field slice constants.
- Sub-module `xbox_xlr_port_mux`:
  - takes one active read request and one active write request (instance, addr, data);
  - drives the per-instance `xlr_mem_*` vectors, zeroing idle instances.

## Test plan
- **Copy:** mem0 lines 2..5 preloaded; src=0/2, dst=1/8, N=4, go at T. Expect `wr` on mem1 at T+3,6,9,12 with addrs 8..11 and matching data. Done at T+13; reg4=4.
- **Range error:** src mem=NUM_MEMS (2). Expect err=1 and done=1 at T+1, and zero strobes. Also: dst line 14 with N=3 → err.
- **Edge cases:** N=0 gives done at T+1 with no access. go while busy changes nothing, and the original command completes on schedule.
- **Abort:** abort issued during the 2nd line's CAP, N=4. Exactly 1 write is seen, then aborted=1, done=1, reg4=1, plus one further… no further strobes.
- **Reset mid-command:** rst during WR of line 2. All outputs are 0 the next cycle. A fresh go afterwards copies correctly.
- **Fill (`XBOX_COPY_FILL_EN`):** reg5=0xA5A5A5A5, N=3, dst=0/0. Writes at T+1..T+3 carry the pattern; done at T+4.
